// File: rtl/dram_rx_pkg.sv
// Shared definitions for the DRAM command receive front end: command field layout,
// decoded command payload, read-tracking states and error-flag bit positions.
package dram_rx_pkg;

  localparam int unsigned CMD_W     = 34;
  localparam int unsigned NUM_BANKS = 8;
  localparam int unsigned RANK_LSB  = 32;
  localparam int unsigned RW_BIT    = 31;
  localparam int unsigned ROW_LSB   = 17;
  localparam int unsigned ROW_W     = 13;
  localparam int unsigned BL_BIT    = 15;
  localparam int unsigned AP_BIT    = 13;
  localparam int unsigned COL_LSB   = 3;
  localparam int unsigned COL_W     = 10;
  localparam int unsigned BANK_W    = 3;

  localparam int unsigned ERR_CMD_OVF   = 0;
  localparam int unsigned ERR_WD_OVF    = 1;
  localparam int unsigned ERR_RD_UNEXP  = 2;
  localparam int unsigned ERR_MALFORMED = 3;

  typedef struct packed {
    logic [1:0]        rank;
    logic              rw;
    logic [ROW_W-1:0]  row;
    logic              bl;
    logic              auto_pre;
    logic [COL_W-1:0]  col;
    logic [BANK_W-1:0] bank;
  } rx_cmd_t;

  localparam int unsigned RX_CMD_W = $bits(rx_cmd_t);

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_PEND = 2'd1,
    RD_FULL = 2'd2
  } rd_state_e;

  // Strip the reserved bits out of the host command word.
  function automatic rx_cmd_t decode_cmd(input logic [CMD_W-1:0] c);
    rx_cmd_t d;
    d.rank     = c[RANK_LSB +: 2];
    d.rw       = c[RW_BIT];
    d.row      = c[ROW_LSB +: ROW_W];
    d.bl       = c[BL_BIT];
    d.auto_pre = c[AP_BIT];
    d.col      = c[COL_LSB +: COL_W];
    d.bank     = c[0 +: BANK_W];
    return d;
  endfunction

  // Reserved bits set, or column not aligned to an 8-beat burst.
  function automatic logic cmd_malformed(input logic [CMD_W-1:0] c);
    return c[30] | c[16] | c[14] | (c[COL_LSB +: 3] != 3'd0);
  endfunction

endpackage

// File: rtl/dram_cmd_rx_if.sv
// Host, scheduler and PHY-return signals of the DRAM command receiver.
interface dram_cmd_rx_if
  import dram_rx_pkg::*;
#(
  parameter int unsigned DQ_BITS = 16
);
  localparam int unsigned DW = DQ_BITS * 8;

  logic                 valid;
  logic [CMD_W-1:0]     command;
  logic [DW-1:0]        write_data;
  logic [NUM_BANKS-1:0] ba_cmd_pm;
  logic                 sch_valid;
  logic                 sch_ready;
  logic [1:0]           sch_rank;
  logic                 sch_rw;
  logic [ROW_W-1:0]     sch_row;
  logic [COL_W-1:0]     sch_col;
  logic [BANK_W-1:0]    sch_bank;
  logic                 sch_bl;
  logic                 sch_auto_pre;
  logic [DW-1:0]        sch_wdata;
  logic [DW-1:0]        phy_rdata;
  logic                 phy_rdata_valid;
  logic [DW-1:0]        read_data;
  logic                 read_data_valid;
  logic [3:0]           rx_err;

  modport master (
    output valid, command, write_data, sch_ready, phy_rdata, phy_rdata_valid,
    input  ba_cmd_pm, sch_valid, sch_rank, sch_rw, sch_row, sch_col, sch_bank,
           sch_bl, sch_auto_pre, sch_wdata, read_data, read_data_valid, rx_err
  );

  modport slave (
    input  valid, command, write_data, sch_ready, phy_rdata, phy_rdata_valid,
    output ba_cmd_pm, sch_valid, sch_rank, sch_rw, sch_row, sch_col, sch_bank,
           sch_bl, sch_auto_pre, sch_wdata, read_data, read_data_valid, rx_err
  );

endinterface

// File: rtl/rx_sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers; a push into a full FIFO
// is taken only when a pop frees the slot in the same cycle.
module rx_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   free
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == PW'(DEPTH));
  assign free    = PW'(DEPTH) - count;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dram_cmd_rx.sv
// DRAM controller command receiver: queues host commands/write data, paces the host
// per bank, feeds the scheduler and returns read data. RX_CMD_CHECK_EN drops malformed commands.
module dram_cmd_rx
  import dram_rx_pkg::*;
#(
  parameter int unsigned DQ_BITS   = 16,
  parameter int unsigned CMD_DEPTH = 8,
  parameter int unsigned WD_DEPTH  = 8,
  parameter int unsigned BANK_MAX  = 4,
  parameter int unsigned RD_MAX    = 15
) (
  input  logic          clk,
  input  logic          power_on_rst,
  dram_cmd_rx_if.slave  bus
);
  localparam int unsigned DW  = DQ_BITS * 8;
  localparam int unsigned CFW = $clog2(CMD_DEPTH) + 1;
  localparam int unsigned WFW = $clog2(WD_DEPTH) + 1;
  localparam int unsigned BCW = $clog2(CMD_DEPTH + 1);
  // Queued reads may still pop after ready drops, so leave headroom above RD_MAX.
  localparam int unsigned RCW = $clog2(RD_MAX + CMD_DEPTH + 2);

  rx_cmd_t              cmd_head;
  logic [RX_CMD_W-1:0]  cmd_head_raw;
  logic                 cmd_empty, cmd_full, wd_empty, wd_full;
  logic [CFW-1:0]       cmd_free;
  logic [WFW-1:0]       wd_free;
  logic [DW-1:0]        wd_head;
  logic                 malformed, is_rd, cmd_room, wd_room, accept, pop;
  logic                 rd_inc, rd_dec, rd_unexp;
  logic [BCW-1:0]       bank_cnt [NUM_BANKS];
  logic [NUM_BANKS-1:0] ba_cmd_pm_q;
  rd_state_e            rd_state;
  logic [RCW-1:0]       rd_out, rd_out_nxt;
  logic [DW-1:0]        read_data_q;
  logic                 read_data_valid_q;
  logic [3:0]           rx_err_q;
  logic                 unused_ok;

`ifdef RX_CMD_CHECK_EN
  assign malformed = cmd_malformed(bus.command);
`else
  assign malformed = 1'b0;
`endif
  assign unused_ok = ^{wd_empty, bus.command[30], bus.command[16], bus.command[14]};

  assign cmd_head = cmd_head_raw;
  assign pop      = !cmd_empty && bus.sch_ready;
  assign is_rd    = bus.command[RW_BIT];
  assign cmd_room = !cmd_full || pop;
  assign wd_room  = !wd_full || (pop && !cmd_head.rw);
  assign accept   = bus.valid && !malformed && cmd_room && (is_rd || wd_room);
  assign rd_inc   = pop && cmd_head.rw;
  assign rd_dec   = bus.phy_rdata_valid && (rd_state != RD_IDLE);
  assign rd_unexp = bus.phy_rdata_valid && (rd_state == RD_IDLE);

  rx_sync_fifo #(.WIDTH(RX_CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(clk), .rst(power_on_rst), .push(accept), .wdata(decode_cmd(bus.command)),
    .pop(pop), .rdata(cmd_head_raw), .empty(cmd_empty), .full(cmd_full), .free(cmd_free)
  );

  rx_sync_fifo #(.WIDTH(DW), .DEPTH(WD_DEPTH)) u_wd_fifo (
    .clk(clk), .rst(power_on_rst), .push(accept && !is_rd), .wdata(bus.write_data),
    .pop(pop && !cmd_head.rw), .rdata(wd_head), .empty(wd_empty), .full(wd_full), .free(wd_free)
  );

  // Per-bank occupancy of the command queue.
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      if (power_on_rst) begin
        bank_cnt[b] <= '0;
      end else begin
        if ((accept && bus.command[BANK_W-1:0] == BANK_W'(b)) && !(pop && cmd_head.bank == BANK_W'(b)))
          bank_cnt[b] <= bank_cnt[b] + BCW'(1);
        else if (!(accept && bus.command[BANK_W-1:0] == BANK_W'(b)) && (pop && cmd_head.bank == BANK_W'(b)))
          bank_cnt[b] <= bank_cnt[b] - BCW'(1);
      end
    end
  end

  // Free-space margin of 2 absorbs the one-cycle latency of the registered ready.
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      if (power_on_rst)
        ba_cmd_pm_q[b] <= 1'b0;
      else
        ba_cmd_pm_q[b] <= (cmd_free >= CFW'(2)) && (wd_free >= WFW'(2)) &&
                          (bank_cnt[b] < BCW'(BANK_MAX)) && (rd_state != RD_FULL);
    end
  end

  always_comb begin
    rd_out_nxt = rd_out;
    if (rd_inc && !rd_dec)      rd_out_nxt = rd_out + RCW'(1);
    else if (!rd_inc && rd_dec) rd_out_nxt = rd_out - RCW'(1);
  end

  // Outstanding-read tracker.
  always_ff @(posedge clk) begin
    if (power_on_rst) begin
      rd_state <= RD_IDLE;
      rd_out   <= '0;
    end else begin
      rd_out <= rd_out_nxt;
      if (rd_out_nxt == '0)                 rd_state <= RD_IDLE;
      else if (rd_out_nxt >= RCW'(RD_MAX))  rd_state <= RD_FULL;
      else                                  rd_state <= RD_PEND;
    end
  end

  // Read return register and sticky error flags.
  always_ff @(posedge clk) begin
    if (power_on_rst) begin
      read_data_q       <= '0;
      read_data_valid_q <= 1'b0;
      rx_err_q          <= '0;
    end else begin
      read_data_valid_q <= rd_dec;
      if (rd_dec) read_data_q <= bus.phy_rdata;
      if (bus.valid && !malformed && !cmd_room)           rx_err_q[ERR_CMD_OVF]   <= 1'b1;
      if (bus.valid && !malformed && !is_rd && !wd_room)  rx_err_q[ERR_WD_OVF]    <= 1'b1;
      if (rd_unexp)                                       rx_err_q[ERR_RD_UNEXP]  <= 1'b1;
      if (bus.valid && malformed)                         rx_err_q[ERR_MALFORMED] <= 1'b1;
    end
  end

  assign bus.ba_cmd_pm       = ba_cmd_pm_q;
  assign bus.sch_valid       = !cmd_empty;
  assign bus.sch_rank        = cmd_head.rank;
  assign bus.sch_rw          = cmd_head.rw;
  assign bus.sch_row         = cmd_head.row;
  assign bus.sch_col         = cmd_head.col;
  assign bus.sch_bank        = cmd_head.bank;
  assign bus.sch_bl          = cmd_head.bl;
  assign bus.sch_auto_pre    = cmd_head.auto_pre;
  assign bus.sch_wdata       = wd_head;
  assign bus.read_data       = read_data_q;
  assign bus.read_data_valid = read_data_valid_q;
  assign bus.rx_err          = rx_err_q;

endmodule

// File: tb/tb_dram_cmd_rx.sv
// Testbench for dram_cmd_rx: directed scenarios plus randomized legal-host traffic
// checked against a queue-based reference model.
module tb_dram_cmd_rx;
  localparam int CD = 8;
  localparam int WD = 8;
  localparam int BMAX = 4;
  localparam int RMAX = 15;

  logic clk = 1'b0;
  logic power_on_rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  dram_cmd_rx_if #(.DQ_BITS(16)) bus ();

  dram_cmd_rx #(.DQ_BITS(16), .CMD_DEPTH(CD), .WD_DEPTH(WD), .BANK_MAX(BMAX), .RD_MAX(RMAX)) dut (
    .clk(clk), .power_on_rst(power_on_rst), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state: queued commands, queued write data, outstanding reads.
  logic [33:0]  cq [$];
  logic [127:0] wq [$];
  int           m_rd_out;
  logic [7:0]   m_ba;
  logic [3:0]   m_err;
  logic         m_rdv;
  logic [127:0] m_rdd;

  function automatic logic [33:0] mk_cmd(input int rank, input int rw, input int row,
                                         input int col, input int bank);
    return {2'(rank), 1'(rw), 1'b0, 13'(row), 1'b0, 1'b0, 1'b0, 1'b0, 10'(col), 3'(bank)};
  endfunction

  function automatic logic bad_cmd(input logic [33:0] c);
    logic [9:0] col;
    col = c[12:3];
    return c[30] || c[16] || c[14] || (col % 8 != 0);
  endfunction

  // Apply one clock of the current inputs to the model, then advance the DUT.
  task automatic tick();
    logic pop, hrw, mal, is_rd, croom, wroom, acc;
    int   bcnt [8];
    if (power_on_rst) begin
      cq.delete(); wq.delete();
      m_rd_out = 0; m_ba = '0; m_err = '0; m_rdv = 1'b0; m_rdd = '0;
    end else begin
      pop   = (cq.size() > 0) && bus.sch_ready;
      hrw   = pop ? cq[0][31] : 1'b0;
`ifdef RX_CMD_CHECK_EN
      mal   = bad_cmd(bus.command);
`else
      mal   = 1'b0;
`endif
      is_rd = bus.command[31];
      croom = (cq.size() < CD) || pop;
      wroom = (wq.size() < WD) || (pop && !hrw);
      acc   = bus.valid && !mal && croom && (is_rd || wroom);
      if (bus.valid && !mal && !croom)          m_err[0] = 1'b1;
      if (bus.valid && !mal && !is_rd && !wroom) m_err[1] = 1'b1;
      if (bus.valid && mal)                      m_err[3] = 1'b1;
      if (bus.phy_rdata_valid && m_rd_out == 0)  m_err[2] = 1'b1;
      foreach (bcnt[b]) bcnt[b] = 0;
      foreach (cq[i]) bcnt[int'(cq[i][2:0])]++;
      for (int b = 0; b < 8; b++)
        m_ba[b] = (CD - cq.size() >= 2) && (WD - wq.size() >= 2) && (bcnt[b] < BMAX) && (m_rd_out < RMAX);
      m_rdv = bus.phy_rdata_valid && (m_rd_out > 0);
      if (m_rdv) begin
        m_rdd = bus.phy_rdata;
        m_rd_out--;
      end
      if (pop && hrw) m_rd_out++;
      if (pop) begin
        void'(cq.pop_front());
        if (!hrw) void'(wq.pop_front());
      end
      if (acc) begin
        cq.push_back(bus.command);
        if (!is_rd) wq.push_back(bus.write_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid = 1'b0; bus.command = '0; bus.write_data = '0; bus.sch_ready = 1'b0;
    bus.phy_rdata = '0; bus.phy_rdata_valid = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    power_on_rst = 1'b1;
    tick(); tick();
    power_on_rst = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    power_on_rst = 1'b1;
    tick(); tick();
    n_tests++; if (bus.ba_cmd_pm !== 8'h00) begin n_fail++; $display("FAIL rst_ba got %h want 00", bus.ba_cmd_pm); end
    n_tests++; if (bus.sch_valid !== 1'b0) begin n_fail++; $display("FAIL rst_sch_valid got %b want 0", bus.sch_valid); end
    n_tests++; if (bus.rx_err !== 4'h0) begin n_fail++; $display("FAIL rst_err got %h want 0", bus.rx_err); end
    n_tests++; if ({bus.read_data_valid, bus.read_data} !== 129'd0) begin n_fail++; $display("FAIL rst_rdata got %b/%h want 0/0", bus.read_data_valid, bus.read_data); end
    power_on_rst = 1'b0;
    tick();
    n_tests++; if (bus.ba_cmd_pm !== 8'hFF) begin n_fail++; $display("FAIL rel_ba got %h want ff", bus.ba_cmd_pm); end
    n_tests++; if (bus.sch_valid !== 1'b0) begin n_fail++; $display("FAIL rel_sch_valid got %b want 0", bus.sch_valid); end
  endtask

  task automatic test_write_read();
    apply_reset();
    bus.valid = 1'b1; bus.command = mk_cmd(0, 0, 5, 8, 0); bus.write_data = {16{8'hA5}};
    tick();
    bus.command = mk_cmd(0, 1, 5, 8, 0); bus.write_data = '0;
    tick();
    bus.valid = 1'b0;
    n_tests++;
    if ({bus.sch_valid, bus.sch_rank, bus.sch_rw, bus.sch_row, bus.sch_col, bus.sch_bank} !== {1'b1, 2'd0, 1'b0, 13'd5, 10'd8, 3'd0}) begin
      n_fail++; $display("FAIL wr_head got v%b rk%0d rw%b row%0d col%0d bk%0d want v1 rk0 rw0 row5 col8 bk0",
                         bus.sch_valid, bus.sch_rank, bus.sch_rw, bus.sch_row, bus.sch_col, bus.sch_bank);
    end
    n_tests++; if (bus.sch_wdata !== {16{8'hA5}}) begin n_fail++; $display("FAIL wr_wdata got %h want a5..a5", bus.sch_wdata); end
    bus.sch_ready = 1'b1;
    tick();
    n_tests++;
    if ({bus.sch_valid, bus.sch_rw, bus.sch_row, bus.sch_col} !== {1'b1, 1'b1, 13'd5, 10'd8}) begin
      n_fail++; $display("FAIL rd_head got v%b rw%b row%0d col%0d want v1 rw1 row5 col8", bus.sch_valid, bus.sch_rw, bus.sch_row, bus.sch_col);
    end
    tick();
    bus.sch_ready = 1'b0;
    n_tests++; if (bus.sch_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_drained got %b want 0", bus.sch_valid); end
    bus.phy_rdata = 128'h1234; bus.phy_rdata_valid = 1'b1;
    tick();
    bus.phy_rdata_valid = 1'b0; bus.phy_rdata = '1;
    n_tests++; if ({bus.read_data_valid, bus.read_data} !== {1'b1, 128'h1234}) begin n_fail++; $display("FAIL wr_rd_return got %b/%h want 1/1234", bus.read_data_valid, bus.read_data); end
    tick();
    n_tests++; if ({bus.read_data_valid, bus.read_data} !== {1'b0, 128'h1234}) begin n_fail++; $display("FAIL wr_rd_hold got %b/%h want 0/1234", bus.read_data_valid, bus.read_data); end
    n_tests++; if (bus.rx_err !== 4'h0) begin n_fail++; $display("FAIL wr_rd_err got %h want 0", bus.rx_err); end
  endtask

  task automatic test_bank_ready();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      bus.valid = 1'b1; bus.command = mk_cmd(1, 1, i, 16, 2);
      tick();
    end
    bus.valid = 1'b0;
    tick();
    n_tests++; if (bus.ba_cmd_pm !== 8'hFB) begin n_fail++; $display("FAIL bank_full got %h want fb", bus.ba_cmd_pm); end
    bus.sch_ready = 1'b1;
    tick();
    bus.sch_ready = 1'b0;
    n_tests++; if (bus.ba_cmd_pm !== 8'hFB) begin n_fail++; $display("FAIL bank_pop_lat got %h want fb", bus.ba_cmd_pm); end
    tick();
    n_tests++; if (bus.ba_cmd_pm !== 8'hFF) begin n_fail++; $display("FAIL bank_reopen got %h want ff", bus.ba_cmd_pm); end
  endtask

  task automatic test_overflow();
    int cnt, first_row, last_row;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      bus.valid = 1'b1; bus.command = mk_cmd(0, 1, i, 0, i);
      tick();
    end
    bus.command = mk_cmd(0, 1, 8, 0, 0); bus.sch_ready = 1'b1;
    tick();
    n_tests++; if (bus.rx_err !== 4'h0) begin n_fail++; $display("FAIL ovf_pushpop_err got %h want 0", bus.rx_err); end
    bus.command = mk_cmd(0, 1, 9, 0, 1); bus.sch_ready = 1'b0;
    tick();
    bus.valid = 1'b0;
    n_tests++; if (bus.rx_err !== 4'h1) begin n_fail++; $display("FAIL ovf_err got %h want 1", bus.rx_err); end
    n_tests++; if (bus.ba_cmd_pm !== 8'h00) begin n_fail++; $display("FAIL ovf_ba got %h want 00", bus.ba_cmd_pm); end
    cnt = 0; first_row = -1; last_row = -1;
    bus.sch_ready = 1'b1;
    for (int k = 0; k < 20 && bus.sch_valid === 1'b1; k++) begin
      if (cnt == 0) first_row = int'(bus.sch_row);
      last_row = int'(bus.sch_row);
      cnt++;
      tick();
    end
    bus.sch_ready = 1'b0;
    n_tests++; if (cnt != 8) begin n_fail++; $display("FAIL ovf_count got %0d want 8", cnt); end
    n_tests++; if (first_row != 1 || last_row != 8) begin n_fail++; $display("FAIL ovf_order got %0d..%0d want 1..8", first_row, last_row); end
  endtask

  task automatic test_read_return();
    apply_reset();
    bus.sch_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.valid = 1'b1; bus.command = mk_cmd(2, 1, 100 + i, 64, i);
      tick();
    end
    bus.valid = 1'b0;
    tick();
    bus.sch_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus.phy_rdata = 128'(i); bus.phy_rdata_valid = 1'b1;
      tick();
      n_tests++;
      if ({bus.read_data_valid, bus.read_data} !== {1'b1, 128'(i)}) begin
        n_fail++; $display("FAIL ret_%0d got %b/%h want 1/%0h", i, bus.read_data_valid, bus.read_data, i);
      end
    end
    bus.phy_rdata_valid = 1'b0;
    tick();
    n_tests++; if ({bus.read_data_valid, bus.read_data, bus.rx_err} !== {1'b0, 128'h3, 4'h0}) begin
      n_fail++; $display("FAIL ret_idle got %b/%h err %h want 0/3 err 0", bus.read_data_valid, bus.read_data, bus.rx_err);
    end
    bus.phy_rdata = 128'h4; bus.phy_rdata_valid = 1'b1;
    tick();
    bus.phy_rdata_valid = 1'b0;
    n_tests++; if (bus.rx_err !== 4'h4) begin n_fail++; $display("FAIL ret_unexp got %h want 4", bus.rx_err); end
  endtask

  task automatic test_cmd_check();
    apply_reset();
    bus.valid = 1'b1; bus.command = mk_cmd(0, 1, 7, 3, 5);
    tick();
    bus.valid = 1'b0;
`ifdef RX_CMD_CHECK_EN
    n_tests++; if ({bus.sch_valid, bus.rx_err} !== {1'b0, 4'h8}) begin
      n_fail++; $display("FAIL chk_drop got v%b err %h want v0 err 8", bus.sch_valid, bus.rx_err);
    end
`else
    n_tests++; if ({bus.sch_valid, bus.sch_col, bus.rx_err} !== {1'b1, 10'd3, 4'h0}) begin
      n_fail++; $display("FAIL chk_pass got v%b col %0d err %h want v1 col 3 err 0", bus.sch_valid, bus.sch_col, bus.rx_err);
    end
`endif
  endtask

  task automatic test_random();
    logic [33:0] c;
    logic [30:0] exp_head;
    int bank;
    apply_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      n_tests++;
      if (bus.sch_valid !== (cq.size() > 0)) begin
        n_fail++; $display("FAIL rnd_sch_valid cyc %0d got %b want %b", cyc, bus.sch_valid, cq.size() > 0);
      end
      if (cq.size() > 0) begin
        c = cq[0];
        exp_head = {c[33:32], c[31], c[29:17], c[15], c[13], c[12:3], c[2:0]};
        n_tests++;
        if ({bus.sch_rank, bus.sch_rw, bus.sch_row, bus.sch_bl, bus.sch_auto_pre, bus.sch_col, bus.sch_bank} !== exp_head) begin
          n_fail++; $display("FAIL rnd_head cyc %0d got %h want %h", cyc,
                             {bus.sch_rank, bus.sch_rw, bus.sch_row, bus.sch_bl, bus.sch_auto_pre, bus.sch_col, bus.sch_bank}, exp_head);
        end
        if (!c[31] && wq.size() > 0) begin
          n_tests++;
          if (bus.sch_wdata !== wq[0]) begin n_fail++; $display("FAIL rnd_wdata cyc %0d got %h want %h", cyc, bus.sch_wdata, wq[0]); end
        end
      end
      n_tests++;
      if ({bus.ba_cmd_pm, bus.rx_err, bus.read_data_valid} !== {m_ba, m_err, m_rdv}) begin
        n_fail++; $display("FAIL rnd_status cyc %0d got ba %h err %h rdv %b want ba %h err %h rdv %b",
                           cyc, bus.ba_cmd_pm, bus.rx_err, bus.read_data_valid, m_ba, m_err, m_rdv);
      end
      n_tests++;
      if (bus.read_data !== m_rdd) begin n_fail++; $display("FAIL rnd_rdata cyc %0d got %h want %h", cyc, bus.read_data, m_rdd); end
      bank = int'($urandom_range(0, 7));
      c = mk_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 8191)),
                 int'($urandom_range(0, 127)) * 8, bank);
      if ($urandom_range(0, 15) == 0) c[5:3] = 3'($urandom_range(1, 7));
      c[15] = 1'($urandom); c[13] = 1'($urandom);
      bus.valid      = bus.ba_cmd_pm[bank] && ($urandom_range(0, 1) == 1);
      bus.command    = c;
      bus.write_data = {$urandom, $urandom, $urandom, $urandom};
      bus.sch_ready  = ($urandom_range(0, 2) != 0);
      bus.phy_rdata  = {$urandom, $urandom, $urandom, $urandom};
      bus.phy_rdata_valid = (m_rd_out > 0) && ($urandom_range(0, 2) != 0);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    power_on_rst = 1'b1;
    test_reset();
    test_write_read();
    test_bank_ready();
    test_overflow();
    test_read_return();
    test_cmd_check();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
